z_core_axil_ram: RTL and testbench

- AXI-Lite slave word memory.
- Sits directly downstream of the core's AXI-Lite master port and serves both instruction fetches and load/store traffic for z_core_control_u.
- Write and read channels are independent, with byte-strobe writes and one-cycle read latency.
- Serves as the bench and system memory for the core.

---
 rtl/z_core_axil_pkg.sv | 16 +
 rtl/z_core_axil_ram_if.sv | 40 ++++
 rtl/z_core_dp_ram.sv | 35 +++
 rtl/z_core_axil_ram.sv | 107 ++++++++++
 tb/tb_z_core_axil_ram.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/z_core_axil_pkg.sv
// Shared AXI-Lite definitions for the z_core memory-side blocks.
package z_core_axil_pkg;

  localparam int unsigned AXIL_DATA_WIDTH = 32;
  localparam int unsigned AXIL_STRB_WIDTH = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Write-data beat as captured from the W channel
  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [AXIL_STRB_WIDTH-1:0] strb;
  } axil_w_t;

endpackage

// File: rtl/z_core_axil_ram_if.sv
// AXI-Lite bus bundle between the core's master port and its memory slave.
interface z_core_axil_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/z_core_dp_ram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port,
// read-before-write when both ports hit the same word on one edge.
module z_core_dp_ram
  import z_core_axil_pkg::*;
#(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter string       INIT_FILE      = ""
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXIL_STRB_WIDTH-1:0] wr_be,
  input  logic [MEM_WORDS_LOG2-1:0]  wr_addr,
  input  logic [AXIL_DATA_WIDTH-1:0] wr_data,
  input  logic                       rd_en,
  input  logic [MEM_WORDS_LOG2-1:0]  rd_addr,
  output logic [AXIL_DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned WORDS = 32'(1) << MEM_WORDS_LOG2;

  logic [AXIL_DATA_WIDTH-1:0] mem [WORDS];

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(AXIL_STRB_WIDTH); i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/z_core_axil_ram.sv
// AXI-Lite slave word memory: independent write/read channels, byte strobes,
// one-cycle read latency, always-OKAY responses.
module z_core_axil_ram
  import z_core_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter string       INIT_FILE      = ""
) (
  input  logic             clk,
  input  logic             rstn,
  z_core_axil_ram_if.slave s_axil
);

  localparam int unsigned IDX_W = MEM_WORDS_LOG2;

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_addr;
  logic                  w_held;
  axil_w_t               w_buf;
  logic                  bvalid;
  logic                  rvalid;

  logic                  aw_take;
  logic                  w_take;
  logic                  ar_take;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  axil_w_t               w_cur;
  logic [STRB_WIDTH-1:0] wr_be;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_ok;

  assign s_axil.awready = ~aw_held & ~bvalid;
  assign s_axil.wready  = ~w_held & ~bvalid;
  assign s_axil.arready = ~rvalid | s_axil.rready;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.bresp   = AXI_RESP_OKAY;
  assign s_axil.rresp   = AXI_RESP_OKAY;
  assign s_axil.rdata   = rd_data;

  assign aw_take = s_axil.awvalid & s_axil.awready;
  assign w_take  = s_axil.wvalid & s_axil.wready;
  assign ar_take = s_axil.arvalid & s_axil.arready;
  assign commit  = (aw_held | aw_take) & (w_held | w_take);

  // A held beat takes precedence over the live bus when forming the write
  assign wr_idx = aw_held ? aw_addr : s_axil.awaddr[IDX_W+1:2];
  assign w_cur  = w_held ? w_buf : axil_w_t'{data: s_axil.wdata, strb: s_axil.wstrb};
  assign wr_be  = commit ? w_cur.strb : '0;

  assign unused_ok = ^{s_axil.awprot, s_axil.arprot,
                       s_axil.awaddr[1:0], s_axil.araddr[1:0],
                       s_axil.awaddr[ADDR_WIDTH-1:IDX_W+2],
                       s_axil.araddr[ADDR_WIDTH-1:IDX_W+2]};

  // Write channel: hold whichever of AW/W arrives first until the pair commits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held <= 1'b0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_buf   <= '0;
      bvalid  <= 1'b0;
    end else begin
      if (bvalid && s_axil.bready) bvalid <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
      end else begin
        if (aw_take) begin
          aw_held <= 1'b1;
          aw_addr <= s_axil.awaddr[IDX_W+1:2];
        end
        if (w_take) begin
          w_held <= 1'b1;
          w_buf  <= axil_w_t'{data: s_axil.wdata, strb: s_axil.wstrb};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              rvalid <= 1'b0;
    else if (ar_take)       rvalid <= 1'b1;
    else if (s_axil.rready) rvalid <= 1'b0;
  end

  z_core_dp_ram #(
    .MEM_WORDS_LOG2 (MEM_WORDS_LOG2),
    .INIT_FILE      (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_be   (wr_be),
    .wr_addr (wr_idx),
    .wr_data (w_cur.data),
    .rd_en   (ar_take),
    .rd_addr (s_axil.araddr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_z_core_axil_ram.sv
// Directed bench for z_core_axil_ram: handshakes, strobes, backpressure,
// read/write collision, aliasing and mid-transaction reset.
module tb_z_core_axil_ram;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic [31:0] vals [4] = '{32'h0A0B_0C00, 32'h0A0B_0C01, 32'h0A0B_0C02, 32'h0A0B_0C03};

  z_core_axil_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

  z_core_axil_ram #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .STRB_WIDTH     (4),
    .MEM_WORDS_LOG2 (12),
    .INIT_FILE      ("")
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_axil (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit ack);
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wr_bvalid", 32'(bus.bvalid), 32'd1);
    check("wr_bresp", 32'(bus.bresp), 32'd0);
    if (ack) begin
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check("wr_bvalid_clr", 32'(bus.bvalid), 32'd0);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b0;
    step();
    bus.arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check(tag, bus.rdata, exp);
    check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b1;
    bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Asynchronous reset mid-cycle, before any clock edge
    #3 rstn = 1'b0;
    #1;
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_wready", 32'(bus.wready), 32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_rdata", bus.rdata, 32'd0);
    step(); step();
    rstn = 1'b1;
    step();

    // Full write then read, bvalid held while bready low
    do_write(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    check("wr_awready_busy", 32'(bus.awready), 32'd0);
    step();
    check("wr_bvalid_held", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("wr_bvalid_clr0", 32'(bus.bvalid), 32'd0);
    check("wr_awready_back", 32'(bus.awready), 32'd1);
    do_read("rd_full", 32'h100, 32'hDEADBEEF);

    // W first with strobes 0101, AW three cycles later
    bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'b0101;
    step();
    bus.wvalid = 1'b0;
    check("ooo_wready_low", 32'(bus.wready), 32'd0);
    check("ooo_awready_hi", 32'(bus.awready), 32'd1);
    step();
    check("ooo_no_bvalid", 32'(bus.bvalid), 32'd0);
    step();
    bus.awvalid = 1'b1; bus.awaddr = 32'h100;
    step();
    bus.awvalid = 1'b0;
    check("ooo_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    do_read("rd_ooo", 32'h100, 32'hDE22BE44);

    // Zero strobe: response only, memory unchanged
    do_write(32'h100, 32'hFFFFFFFF, 4'h0, 1'b1);
    do_read("rd_strb0", 32'h100, 32'hDE22BE44);

    // Backpressure on the second of four reads
    for (int i = 0; i < 4; i++) do_write(32'(4 * i), vals[i], 4'hF, 1'b1);
    bus.rready = 1'b1; bus.arvalid = 1'b1; bus.araddr = 32'h0;
    step();
    check("bp_r0", bus.rdata, vals[0]);
    bus.araddr = 32'h4;
    step();
    check("bp_r1", bus.rdata, vals[1]);
    bus.rready = 1'b0; bus.araddr = 32'h8;
    #1 check("bp_arready_stall", 32'(bus.arready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_rvalid", 32'(bus.rvalid), 32'd1);
      check("bp_hold_rdata", bus.rdata, vals[1]);
      check("bp_hold_arready", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    #1 check("bp_arready_release", 32'(bus.arready), 32'd1);
    step();
    check("bp_r2", bus.rdata, vals[2]);
    bus.araddr = 32'hC;
    step();
    check("bp_r3", bus.rdata, vals[3]);
    bus.arvalid = 1'b0;
    step();
    check("bp_drained", 32'(bus.rvalid), 32'd0);

    // Streaming: one read per cycle, reverse order
    bus.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.araddr = 32'(4 * (3 - i));
      step();
      check("st_rvalid", 32'(bus.rvalid), 32'd1);
      check("st_rdata", bus.rdata, vals[3 - i]);
    end
    bus.arvalid = 1'b0;
    step();
    bus.rready = 1'b0;
    check("st_drained", 32'(bus.rvalid), 32'd0);

    // Collision: read and write commit hit word 0x20 on the same edge
    do_write(32'h20, 32'h0, 4'hF, 1'b1);
    bus.awvalid = 1'b1; bus.awaddr = 32'h20;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h20;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("col_old_data", bus.rdata, 32'h0);
    check("col_bvalid", 32'(bus.bvalid), 32'd1);
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    do_read("col_new_data", 32'h20, 32'hCAFEF00D);

    // Aliasing modulo memory size, then reset with a pending response
    do_write(32'h4000, 32'hA5A5A5A5, 4'hF, 1'b1);
    do_read("alias_rd", 32'h0, 32'hA5A5A5A5);
    do_write(32'h4, 32'h00005555, 4'hF, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("mid_rst_awready", 32'(bus.awready), 32'd1);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    step();
    rstn = 1'b1;
    step();
    check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
    do_read("post_rst_w0", 32'h0, 32'hA5A5A5A5);
    do_read("post_rst_w1", 32'h4, 32'h00005555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
